orcs_mem_loader: RTL and testbench

Boot-time program loader for the ORCS processor. It receives a framed byte stream over a valid/ready port, assembles 16-bit words, and writes them into the 1K-word main memory through that memory's address/data/clken/wren port. It holds the processor core in reset through `cpu_reset_n` until a complete, checked image has been written. It sits directly upstream of the processor: it fills the memory the processor fetches from, then releases the core.

---
 rtl/orcs_mem_loader.sv | 142 ++++++++++++++
 tb/tb_orcs_mem_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/orcs_mem_loader.sv
// Boot loader: framed byte stream -> 16-bit words in main memory; holds the core in reset until done.
// Optional trailing XOR checksum byte enabled by defining ORCS_LOADER_CHECKSUM_EN.
module orcs_mem_loader #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [15:0]       mem_data,
  output logic              mem_clken,
  output logic              mem_wren,
  output logic              cpu_reset_n,
  output logic              load_done,
  output logic              load_error
);

  typedef enum logic [2:0] {
    StCntLo, StCntHi, StWLo, StWHi, StWrite, StCheck, StDone, StError
  } state_e;

  localparam logic [15:0] MaxWords = 16'(MEM_WORDS);

  state_e      state_q, state_d;
  logic        active_q;
  logic [10:0] idx_q, idx_d;
  logic [10:0] last_q, last_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] count;
  logic        xfer;
`ifdef ORCS_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  // active_q keeps rx_ready low during the cycle that follows a reset edge.
  assign rx_ready = active_q &&
                    (state_q inside {StCntLo, StCntHi, StWLo, StWHi, StCheck});
  assign xfer        = rx_valid && rx_ready;
  assign count       = {rx_data, lo_q};
  assign mem_address = idx_q[ADDR_W-1:0];
  assign mem_data    = {hi_q, lo_q};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    mem_clken   = 1'b0;
    mem_wren    = 1'b0;
    load_done   = 1'b0;
    load_error  = 1'b0;
    cpu_reset_n = 1'b0;
`ifdef ORCS_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
    if (xfer && state_q != StCheck) csum_d = csum_q ^ rx_data;
`endif
    unique case (state_q)
      StCntLo: if (xfer) begin
        lo_d    = rx_data;
        state_d = StCntHi;
      end
      StCntHi: if (xfer) begin
        if (count > MaxWords) begin
          state_d = StError;
        end else if (count == 16'd0) begin
`ifdef ORCS_LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end else begin
          last_d  = 11'(count - 16'd1);
          state_d = StWLo;
        end
      end
      StWLo: if (xfer) begin
        lo_d    = rx_data;
        state_d = StWHi;
      end
      StWHi: if (xfer) begin
        hi_d    = rx_data;
        state_d = StWrite;
      end
      StWrite: begin
        mem_clken = 1'b1;
        mem_wren  = 1'b1;
        idx_d     = idx_q + 11'd1;
        if (idx_q == last_q) begin
`ifdef ORCS_LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StWLo;
        end
      end
      StCheck: begin
`ifdef ORCS_LOADER_CHECKSUM_EN
        if (xfer) state_d = (rx_data == csum_q) ? StDone : StError;
`else
        state_d = StError;
`endif
      end
      StDone: begin
        load_done   = 1'b1;
        cpu_reset_n = 1'b1;
      end
      StError: load_error = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StCntLo;
      active_q <= 1'b0;
      idx_q    <= '0;
      last_q   <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
`ifdef ORCS_LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
      idx_q    <= idx_d;
      last_q   <= last_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
`ifdef ORCS_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_orcs_mem_loader.sv
// Randomized bench for orcs_mem_loader: frame-level reference model checked every cycle,
// plus literal expectations for the directed load scenarios.
module tb_orcs_mem_loader;

`ifdef ORCS_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [15:0] word_q_t[$];

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [9:0]  mem_address;
  logic [15:0] mem_data;
  logic        mem_clken, mem_wren, cpu_reset_n, load_done, load_error;

  always #5 clk = ~clk;

  orcs_mem_loader #(.MEM_WORDS(1024), .ADDR_W(10)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_address(mem_address), .mem_data(mem_data),
    .mem_clken(mem_clken), .mem_wren(mem_wren), .cpu_reset_n(cpu_reset_n),
    .load_done(load_done), .load_error(load_error)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory image as seen on the write port.
  logic [15:0] shadow [0:1023];
  int          wr_count = 0;
  always @(negedge clk) if (mem_wren === 1'b1) begin
    shadow[mem_address] = mem_data;
    wr_count++;
  end

  // Frame-level model: expectations for the cycle following each negedge.
  bit          armed = 1'b0;
  bit          m_rst, m_ready, m_write, m_last;
  int          m_term;  // 0 loading, 1 done, 2 error
  int          m_addr;
  logic [15:0] m_data;
  int          nb, n;
  logic [7:0]  nlo, wlo, csum, b;
  bit          xfer, nw;
  int          nterm;

  always @(negedge clk) begin
    if (armed) begin
      chk("rx_ready", rx_ready, m_ready);
      chk("mem_wren", mem_wren, m_write);
      chk("mem_clken", mem_clken, m_write);
      chk("load_done", load_done, m_term == 1);
      chk("load_error", load_error, m_term == 2);
      chk("cpu_reset_n", cpu_reset_n, m_term == 1);
      if (m_write) begin
        chk("wr_addr", mem_address, m_addr);
        chk("wr_data", mem_data, m_data);
      end
      if (m_rst) begin
        chk("rst_addr", mem_address, 0);
        chk("rst_data", mem_data, 0);
      end
    end
    if (!reset_n) begin
      armed = 1'b1; m_rst = 1'b1; m_ready = 1'b0; m_write = 1'b0; m_last = 1'b0;
      m_term = 0; nb = 0; n = 0; csum = 8'h00;
    end else if (armed) begin
      xfer  = rx_valid && m_ready;
      nw    = 1'b0;
      nterm = m_term;
      if (m_write && m_last && !CS) nterm = 1;
      if (xfer) begin
        b = rx_data;
        if (nb == 0) begin
          nlo = b; csum ^= b;
        end else if (nb == 1) begin
          csum ^= b;
          n = {b, nlo};
          if (n > 1024) nterm = 2;
          else if (n == 0 && !CS) nterm = 1;
        end else if (nb < 2 + 2 * n) begin
          csum ^= b;
          if (nb % 2 == 0) wlo = b;
          else begin
            nw = 1'b1; m_addr = (nb - 3) / 2; m_data = {b, wlo}; m_last = (m_addr == n - 1);
          end
        end else begin
          nterm = (b == csum) ? 1 : 2;
        end
        nb++;
      end
      m_rst   = 1'b0;
      m_write = nw;
      m_term  = nterm;
      m_ready = (nterm == 0) && !nw;
    end
  end

  function automatic logic [7:0] xsum(input byte_q_t q);
    logic [7:0] s = 8'h00;
    foreach (q[i]) s ^= q[i];
    return s;
  endfunction

  function automatic byte_q_t make_frame(input word_q_t w, input bit bad);
    byte_q_t     q;
    logic [15:0] cnt;
    cnt = 16'(w.size());
    q.push_back(cnt[7:0]);
    q.push_back(cnt[15:8]);
    foreach (w[i]) begin
      q.push_back(w[i][7:0]);
      q.push_back(w[i][15:8]);
    end
    if (CS) q.push_back(xsum(q) ^ {7'd0, bad});
    return q;
  endfunction

  int gap_pct = 0;

  task automatic send_byte(input logic [7:0] val, input int bound, output bit ok);
    ok = 1'b0;
    if ($urandom_range(0, 99) < gap_pct) begin
      repeat ($urandom_range(1, 3)) begin
        rx_valid = 1'b0; rx_data = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    rx_valid = 1'b1; rx_data = val;
    for (int t = 0; t < bound && !ok; t++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic send_frame(input byte_q_t q, input int bound, output int acc);
    bit ok;
    acc = 0;
    foreach (q[i]) begin
      send_byte(q[i], bound, ok);
      if (!ok) break;
      acc++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_cpu_reset_n", cpu_reset_n, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_mem_wren", mem_wren, 0);
    reset_n = 1'b1;
    wr_count = 0;
    @(posedge clk); #1;
    chk("ready_after_reset", rx_ready, 1);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    byte_q_t fr, pin;
    word_q_t w;
    int      acc;
    bit      ok, bad;

    pin = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB};
    chk("model_csum_pin", xsum(pin), 8'h42);

    @(posedge clk); #1;
    do_reset();

    // Good two-word load
    w = '{16'h1234, 16'hABCD};
    fr = make_frame(w, 1'b0);
    send_frame(fr, 20, acc);
    chk("good_accepted", acc, fr.size());
    settle();
    chk("good_wr_count", wr_count, 2);
    chk("good_word0", shadow[0], 16'h1234);
    chk("good_word1", shadow[1], 16'hABCD);
    chk("good_done", load_done, 1);
    chk("good_cpu_run", cpu_reset_n, 1);
    chk("good_no_error", load_error, 0);
    send_byte(8'h55, 4, ok);
    chk("good_extra_refused", ok, 0);

    // Bad checksum
    if (CS) begin
      do_reset();
      fr = make_frame(w, 1'b1);
      chk("bad_last_byte", fr[6], 8'h43);
      send_frame(fr, 20, acc);
      settle();
      chk("bad_wr_count", wr_count, 2);
      chk("bad_error", load_error, 1);
      chk("bad_cpu_held", cpu_reset_n, 0);
      send_byte(8'h00, 4, ok);
      chk("bad_extra_refused", ok, 0);
    end

    // Empty image
    do_reset();
    w = {};
    fr = make_frame(w, 1'b0);
    send_frame(fr, 20, acc);
    settle();
    chk("empty_wr_count", wr_count, 0);
    chk("empty_done", load_done, 1);

    // Oversize count 1025
    do_reset();
    fr = '{8'h01, 8'h04, 8'h11, 8'h22};
    send_frame(fr, 6, acc);
    chk("over_accepted", acc, 2);
    chk("over_error", load_error, 1);
    chk("over_wr_count", wr_count, 0);

    // Full 1024-word image with gaps
    do_reset();
    gap_pct = 40;
    w = {};
    for (int i = 0; i < 1024; i++) w.push_back(16'($urandom));
    fr = make_frame(w, 1'b0);
    send_frame(fr, 20, acc);
    chk("full_accepted", acc, fr.size());
    settle();
    chk("full_wr_count", wr_count, 1024);
    chk("full_first", shadow[0], w[0]);
    chk("full_last", shadow[1023], w[1023]);
    chk("full_done", load_done, 1);

    // Reset after three of five words
    do_reset();
    w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    fr = make_frame(w, 1'b0);
    fr = fr[0:7];
    send_frame(fr, 20, acc);
    chk("abort_accepted", acc, 8);
    do_reset();
    w = '{16'hBEEF, 16'h0F0F};
    fr = make_frame(w, 1'b0);
    send_frame(fr, 20, acc);
    settle();
    chk("fresh_wr_count", wr_count, 2);
    chk("fresh_word0", shadow[0], 16'hBEEF);
    chk("fresh_word1", shadow[1], 16'h0F0F);
    chk("fresh_done", load_done, 1);

    // Random short frames
    for (int r = 0; r < 8; r++) begin
      do_reset();
      gap_pct = int'($urandom_range(0, 60));
      w = {};
      repeat ($urandom_range(1, 8)) w.push_back(16'($urandom));
      bad = CS && ($urandom_range(0, 2) == 0);
      fr = make_frame(w, bad);
      send_frame(fr, 20, acc);
      settle();
      chk("rand_wr_count", wr_count, w.size());
      chk("rand_done", load_done, !bad);
      chk("rand_error", load_error, bad);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
